dmem_arbiter: RTL

Two-requester arbiter that shares the single-port synchronous data memory between the core load/store unit (port 0) and a secondary master such as a DMA or program loader (port 1). It accepts at most one access per cycle and drives the memory's address, write data, read enable and write enable. Because the memory has one-cycle read latency, the arbiter tracks which port owns the in-flight read and routes the returned data back to that port. Arbitration is round-robin with a bounded hold window so that a streaming master can keep the memory for back-to-back beats.

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_rr_sel.sv | 81 ++++++++
 rtl/dmem_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef logic port_idx_t;

  localparam port_idx_t PORT_LSU = 1'b0;
  localparam port_idx_t PORT_DMA = 1'b1;

endpackage

// File: rtl/dmem_rr_sel.sv
// Two-port grant selector: round-robin with a bounded hold window, or fixed
// priority (port 0 first) when DMEM_ARB_FIXED_PRIO_EN is defined.
module dmem_rr_sel
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst_n,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

  always_comb begin
    gnt_o[0] = req_i[0];
    gnt_o[1] = req_i[1] & ~req_i[0];
  end

`else

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  port_idx_t  rr_ptr_q, rr_ptr_d;
  port_idx_t  last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] hold_inc;
  port_idx_t  gidx;

  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | (rr_ptr_q == PORT_LSU));
    gnt_o[1] = req_i[1] & (~req_i[0] | (rr_ptr_q == PORT_DMA));
    gidx     = gnt_o[1] ? PORT_DMA : PORT_LSU;
  end

  // Under contention the pointer flips once the run reaches MAX_HOLD;
  // a lone requester pulls the pointer to itself so it can keep streaming.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    last_d   = last_q;
    hold_d   = hold_q;
    hold_inc = '0;
    if (|req_i) begin
      if (gidx == last_q) begin
        hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 4'd1;
      end else begin
        hold_inc = 4'd1;
      end
      last_d = gidx;
      hold_d = hold_inc;
      if (&req_i) begin
        if (hold_inc == HOLD_MAX) begin
          rr_ptr_d = ~gidx;
          hold_d   = '0;
        end
      end else begin
        rr_ptr_d = gidx;
      end
    end else begin
      hold_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= PORT_LSU;
      last_q   <= PORT_LSU;
      hold_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port synchronous data memory with
// one-cycle read latency. Build option: DMEM_ARB_FIXED_PRIO_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] gnt;
  logic       granted;
  logic       we_sel;
  logic       rd_valid_q, rd_valid_d;
  port_idx_t  rd_tag_q, rd_tag_d;

  dmem_rr_sel #(
    .MAX_HOLD (MAX_HOLD)
  ) u_sel (
`ifndef DMEM_ARB_FIXED_PRIO_EN
    .clk   (clk),
    .rst_n (rst_n),
`endif
    .req_i ({req1, req0}),
    .gnt_o (gnt)
  );

  always_comb begin
    gnt0         = gnt[0];
    gnt1         = gnt[1];
    granted      = gnt[0] | gnt[1];
    mem_addr     = gnt[1] ? addr1  : addr0;
    mem_wdata    = gnt[1] ? wdata1 : wdata0;
    we_sel       = gnt[1] ? we1    : we0;
    mem_write_en = granted &  we_sel;
    mem_read_en  = granted & ~we_sel;
    rd_valid_d   = mem_read_en;
    rd_tag_d     = gnt[1] ? PORT_DMA : PORT_LSU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_tag_q   <= PORT_LSU;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
    end
  end

  always_comb begin
    rvalid0 = rd_valid_q & (rd_tag_q == PORT_LSU);
    rvalid1 = rd_valid_q & (rd_tag_q == PORT_DMA);
    rdata   = mem_rdata;
  end

endmodule
